// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle multiply/divide unit producing the HI/LO pair
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_q, rneg_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic               sa, sb;
  logic [WIDTH:0]     sum;
  logic [WIDTH+1:0]   diff;
  // operand magnitudes, one shift-add / restoring-subtract step, and final sign correction
  always_comb begin
    sa    = ~op[0] & op_a[WIDTH-1];
    sb    = ~op[0] & op_b[WIDTH-1];
    abs_a = sa ? -op_a : op_a;
    abs_b = sb ? -op_b : op_b;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    diff  = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b0, m_q};
    acc_d = !is_div_q ? {sum, acc_q[WIDTH-1:1]} :
            diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0} :
            {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end
  // control FSM with registered handshake outputs and the architectural HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            state_q  <= RUN;
            busy     <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q    <= sa ^ sb;
            rneg_q   <= sa;
            m_q      <= op[1] ? abs_b : abs_a;
            acc_q    <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            div_zero <= op[1] && op_b == '0;
          end else if (!start) begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        RUN: begin
          if (cancel) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) state_q <= FINISH;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            hi   <= is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo   <= !is_div_q ? prod[WIDTH-1:0] : div_zero ? '1 : quo;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors checked against a transaction-level model of the multiply/divide unit
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = '0, op_b = '0, wr_data = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int          n_chk = 0, n_fail = 0;
  int          left = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0, t_dz;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0, t_hi, t_lo;
  int          lat;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of one operation, straight from the arithmetic definition
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    int sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    dz = 1'b0;
    if (o == 2'b00) begin
      p = 64'(longint'(sa) * longint'(sb));
      h = p[63:32];
      l = p[31:0];
    end else if (o == 2'b01) begin
      p = 64'(a) * 64'(b);
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      dz = 1'b1;
      h = a;
      l = 32'hFFFFFFFF;
    end else if (o == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      h = 32'h0;
      l = 32'h80000000;
    end else if (o == 2'b10) begin
      h = sa % sb;
      l = sa / sb;
    end else begin
      h = a % b;
      l = a / b;
    end
  endfunction

  // Transaction model: an accepted op completes 33 edges later unless cancelled
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      left = 0; m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      if (left == 0) begin
        if (start && !cancel) begin
          model(op, op_a, op_b, p_hi, p_lo, p_dz);
          m_dz = p_dz;
          left = 33;
          m_busy = 1;
        end else if (!start) begin
          if (wr_hi) m_hi = wr_data;
          if (wr_lo) m_lo = wr_data;
        end
      end else if (cancel) begin
        left = 0;
        m_busy = 0;
      end else begin
        left--;
        if (left == 0) begin
          m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
        end
      end
    end
  end

  // Every cycle out of reset, all outputs must match the model
  always @(negedge clk) begin
    if (reset) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1; op = o; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 0;
  endtask

  // Waits (bounded) for done; optionally pokes start and wr_hi at cycle 5 of the run
  task automatic wait_done(input bit inj, output int l);
    l = 0;
    while (!done && l < 40) begin
      if (inj && l == 4) begin
        start = 1; op_a = 32'h7; wr_hi = 1; wr_data = 32'hAAAA5555;
      end
      if (inj && l == 5) begin
        start = 0; wr_hi = 0;
      end
      @(posedge clk);
      l++;
      #1;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input bit inj);
    int l;
    issue(o, a, b);
    wait_done(inj, l);
    chk({nm, "_latency"}, 32'(l), 32'd33);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_dz"}, {31'b0, div_zero}, {31'b0, edz});
  endtask

  initial begin
    // pin the model against hand-computed values
    model(2'b10, 32'hFFFFFFF9, 32'd2, t_hi, t_lo, t_dz);
    chk("model_div_hi", t_hi, 32'hFFFFFFFF);
    chk("model_div_lo", t_lo, 32'hFFFFFFFD);
    model(2'b00, 32'hFFFFFFFD, 32'd7, t_hi, t_lo, t_dz);
    chk("model_mult_lo", t_lo, 32'hFFFFFFEB);
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1;
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0);
    // cancel at cycle 10: no done, HI/LO keep the overflow result
    issue(2'b01, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    #1 cancel = 1;
    @(posedge clk);
    #1 cancel = 0;
    chk("cancel_busy", {31'b0, busy}, 32'd0);
    chk("cancel_done", {31'b0, done}, 32'd0);
    chk("cancel_hi", hi, 32'h0);
    chk("cancel_lo", lo, 32'h80000000);
    run_op("after_cancel", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b0);
    // restart and wr_hi while busy are both ignored
    run_op("ignore_start", 2'b01, 32'h10000, 32'h10000, 32'd1, 32'd0, 1'b0, 1'b1);
    // mthi/mtlo in IDLE
    @(negedge clk);
    wr_hi = 1; wr_lo = 1; wr_data = 32'h12345678;
    @(posedge clk);
    #1 wr_hi = 0; wr_lo = 0;
    chk("mthi", hi, 32'h12345678);
    chk("mtlo", lo, 32'h12345678);
    // start and mtlo together: start wins
    @(negedge clk);
    start = 1; op = 2'b01; op_a = 32'd2; op_b = 32'd3; wr_lo = 1; wr_data = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 0; wr_lo = 0;
    chk("start_wins_lo", lo, 32'h12345678);
    wait_done(1'b0, lat);
    chk("start_wins_latency", 32'(lat), 32'd33);
    chk("start_wins_res_lo", lo, 32'd6);
    chk("start_wins_res_hi", hi, 32'd0);
    // asynchronous reset in the middle of a run
    issue(2'b11, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_dz", {31'b0, div_zero}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
